// File: rtl/led_pattern_shifter_if.sv
// LED pattern shifter signal bundle: step strobe and switches in, LEDs and wrap pulse out.
// The master side drives tick/sw (divider and board switches); the slave side is the shifter.
interface led_pattern_shifter_if #(
    parameter int unsigned LED_W = 8
);
    logic             tick;
    logic [3:0]       sw;
    logic [LED_W-1:0] led;
    logic             wrap;

    modport master (
        output tick,
        output sw,
        input  led,
        input  wrap
    );

    modport slave (
        input  tick,
        input  sw,
        output led,
        output wrap
    );
endinterface

// File: rtl/led_pattern_shifter.sv
// Tick-driven LED pattern engine.
// Advances an LED pattern once per clk_in cycle in which tick is high. sw[3:2] selects
// hold / rotate-left / rotate-right / ping-pong, sw[1] inverts the displayed LEDs and
// sw[0] is ignored. A change of mode reloads INIT_PAT and wins over a coincident tick.
// Optional build macro LED_PATTERN_SW_SYNC_EN: when defined, sw[3:1] pass through a
// two-flop synchronizer before use; when undefined they are used directly.
module led_pattern_shifter #(
    parameter int unsigned     LED_W    = 8,
    parameter logic [LED_W-1:0] INIT_PAT = {{(LED_W-1){1'b0}}, 1'b1}
) (
    input logic                    clk_in,
    input logic                    rst_n,
    led_pattern_shifter_if.slave   ctl
);

    localparam logic [1:0] ModeHold = 2'b00;
    localparam logic [1:0] ModeRotL = 2'b01;
    localparam logic [1:0] ModeRotR = 2'b10;
    localparam logic [1:0] ModePing = 2'b11;

    // Ping-pong travel direction; also preset on every mode change.
    typedef enum logic {
        DirL,
        DirR
    } dir_e;

    logic [LED_W-1:0] pat_q, pat_d;
    dir_e             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic             inv_q;
    logic             wrap_q, wrap_d;

    logic [1:0]       mode_cur;
    logic             inv_cur;
    logic             mode_chg;

    // sw[0] is reserved; tie it off so it is visibly unused.
    logic unused_sw0;
    assign unused_sw0 = ctl.sw[0];

`ifdef LED_PATTERN_SW_SYNC_EN
    logic [2:0] sw_meta_q;
    logic [2:0] sw_sync_q;

    // Two-flop synchronizer for the mode and invert switches.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sw_meta_q <= 3'b000;
            sw_sync_q <= 3'b000;
        end else begin
            sw_meta_q <= ctl.sw[3:1];
            sw_sync_q <= sw_meta_q;
        end
    end

    assign mode_cur = sw_sync_q[2:1];
    assign inv_cur  = sw_sync_q[0];
`else
    assign mode_cur = ctl.sw[3:2];
    assign inv_cur  = ctl.sw[1];
`endif

    assign mode_chg = (mode_cur != mode_q);

    // Next-state: mode reload has priority over stepping; wrap defaults low.
    always_comb begin
        pat_d  = pat_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        wrap_d = 1'b0;

        if (mode_chg) begin
            mode_d = mode_cur;
            pat_d  = INIT_PAT;
            dir_d  = (mode_cur == ModeRotR) ? DirR : DirL;
        end else if (ctl.tick) begin
            unique case (mode_q)
                ModeHold: begin
                    pat_d = pat_q;
                end
                ModeRotL: begin
                    pat_d  = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                    wrap_d = pat_q[LED_W-1];
                end
                ModeRotR: begin
                    pat_d  = {pat_q[0], pat_q[LED_W-1:1]};
                    wrap_d = pat_q[0];
                end
                ModePing: begin
                    unique case (dir_q)
                        DirL: begin
                            // Bounce off the MSB end: reverse and step back in one tick.
                            if (pat_q[LED_W-1]) begin
                                dir_d  = DirR;
                                pat_d  = pat_q >> 1;
                                wrap_d = 1'b1;
                            end else begin
                                pat_d = pat_q << 1;
                            end
                        end
                        DirR: begin
                            if (pat_q[0]) begin
                                dir_d  = DirL;
                                pat_d  = pat_q << 1;
                                wrap_d = 1'b1;
                            end else begin
                                pat_d = pat_q >> 1;
                            end
                        end
                        default: begin
                            dir_d = DirL;
                        end
                    endcase
                end
                default: begin
                    pat_d = pat_q;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            pat_q  <= INIT_PAT;
            dir_q  <= DirL;
            mode_q <= ModeHold;
            inv_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            inv_q  <= inv_cur;
            wrap_q <= wrap_d;
        end
    end

    // Inversion only affects what is displayed, never the pattern state.
    assign ctl.led  = pat_q ^ {LED_W{inv_q}};
    assign ctl.wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_shifter.sv
// Self-checking bench for led_pattern_shifter (LED_W=8, INIT_PAT=8'h01).
// Directed scenarios with literal expectations, then randomized tick/switch/reset traffic
// compared every cycle against an arithmetic reference model.
module tb_led_pattern_shifter;

    localparam int unsigned W    = 8;
    localparam logic [7:0]  INIT = 8'h01;
`ifdef LED_PATTERN_SW_SYNC_EN
    localparam int SYNC_LAT = 3;
`else
    localparam int SYNC_LAT = 1;
`endif

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    led_pattern_shifter_if #(.LED_W(W)) ctl ();

    led_pattern_shifter #(
        .LED_W   (W),
        .INIT_PAT(INIT)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .ctl   (ctl)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pattern as an integer 0..255, direction as "moving up".
    int       m_pat  = 1;
    bit       m_up   = 1'b1;
    int       m_mode = 0;
    bit       m_inv  = 1'b0;
    bit       m_wrap = 1'b0;
    bit [2:0] m_s1   = 3'b000;
    bit [2:0] m_s2   = 3'b000;
    bit       chk_en = 1'b0;

    always @(posedge clk_in) begin
        bit [2:0] cur;
        if (!rst_n) begin
            m_pat  = int'(INIT);
            m_up   = 1'b1;
            m_mode = 0;
            m_inv  = 1'b0;
            m_wrap = 1'b0;
            m_s1   = 3'b000;
            m_s2   = 3'b000;
            chk_en = 1'b1;
        end else begin
`ifdef LED_PATTERN_SW_SYNC_EN
            cur = m_s2;
`else
            cur = ctl.sw[3:1];
`endif
            m_wrap = 1'b0;
            if (int'(cur[2:1]) != m_mode) begin
                m_mode = int'(cur[2:1]);
                m_pat  = int'(INIT);
                m_up   = (m_mode != 2);
            end else if (ctl.tick) begin
                case (m_mode)
                    1: begin
                        m_wrap = (m_pat >= 128);
                        m_pat  = (m_pat * 2) % 256 + m_pat / 128;
                    end
                    2: begin
                        m_wrap = (m_pat % 2 == 1);
                        m_pat  = m_pat / 2 + (m_pat % 2) * 128;
                    end
                    3: begin
                        if (m_up) begin
                            if (m_pat >= 128) begin
                                m_up = 1'b0; m_pat = m_pat / 2; m_wrap = 1'b1;
                            end else begin
                                m_pat = (m_pat * 2) % 256;
                            end
                        end else begin
                            if (m_pat % 2 == 1) begin
                                m_up = 1'b1; m_pat = (m_pat * 2) % 256; m_wrap = 1'b1;
                            end else begin
                                m_pat = m_pat / 2;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            m_inv = cur[0];
            m_s2  = m_s1;
            m_s1  = ctl.sw[3:1];
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk_in) begin
        logic [7:0] exp_led;
        if (chk_en) begin
            exp_led = 8'(m_inv ? (255 - m_pat) : m_pat);
            n_checks++;
            if (ctl.led !== exp_led) begin
                n_fail++;
                $display("FAIL model_led t=%0t got=%h exp=%h", $time, ctl.led, exp_led);
            end
            n_checks++;
            if (ctl.wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL model_wrap t=%0t got=%b exp=%b", $time, ctl.wrap, m_wrap);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] s);
        rst_n    = 1'b0;
        ctl.sw   = s;
        ctl.tick = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (SYNC_LAT + 1) @(negedge clk_in);
    endtask

    task automatic step();
        ctl.tick = 1'b1;
        @(negedge clk_in);
        ctl.tick = 1'b0;
    endtask

    logic [7:0] exp_rl [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] exp_pp [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};

    initial begin
        ctl.tick = 1'b0;
        ctl.sw   = 4'b0100;
        rst_n    = 1'b0;

        // Reset held with tick pulsing and a rotate mode selected.
        for (int i = 0; i < 4; i++) begin
            ctl.tick = ~ctl.tick;
            @(negedge clk_in);
            check("reset_led", ctl.led, 8'h01);
            check("reset_wrap", {7'b0, ctl.wrap}, 8'h00);
        end

        // Rotate left through a full lap.
        do_reset(4'b0100);
        check("rl_start", ctl.led, 8'h01);
        for (int i = 0; i < 8; i++) begin
            step();
            check("rl_led", ctl.led, exp_rl[i]);
            check("rl_wrap", {7'b0, ctl.wrap}, (i == 7) ? 8'h01 : 8'h00);
        end

        // Rotate right from reset wraps immediately.
        do_reset(4'b1000);
        step();
        check("rr_led0", ctl.led, 8'h80);
        check("rr_wrap0", {7'b0, ctl.wrap}, 8'h01);
        step();
        check("rr_led1", ctl.led, 8'h40);
        check("rr_wrap1", {7'b0, ctl.wrap}, 8'h00);

        // Ping-pong bounce off the MSB.
        do_reset(4'b1100);
        for (int i = 0; i < 9; i++) begin
            step();
            check("pp_led", ctl.led, exp_pp[i]);
            check("pp_wrap", {7'b0, ctl.wrap}, (i == 7) ? 8'h01 : 8'h00);
        end

        // Mode change coinciding with a tick: reload wins, tick is dropped.
        do_reset(4'b0100);
        repeat (3) step();
        check("mc_before", ctl.led, 8'h08);
        ctl.sw = 4'b1100;
        repeat (SYNC_LAT - 1) @(negedge clk_in);
        step();
        check("mc_led", ctl.led, 8'h01);
        check("mc_wrap", {7'b0, ctl.wrap}, 8'h00);
        step();
        check("mc_next", ctl.led, 8'h02);

        // Inversion.
        do_reset(4'b0110);
        check("inv_led0", ctl.led, 8'hFE);
        step();
        check("inv_led1", ctl.led, 8'hFD);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            rst_n    = ($urandom_range(0, 249) != 0);
            ctl.tick = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) ctl.sw = 4'($urandom_range(0, 15));
            @(negedge clk_in);
        end

        rst_n    = 1'b1;
        ctl.tick = 1'b0;
        repeat (2) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
